axi_eth_rx_fm: RTL and testbench
================================

Name: axi_eth_rx_fm

Overview:
- Parametrised single-clock successor of the 10GE receive frame manager.
- Accepts the MAC receive AXI-Stream and stores each frame in an internal store-and-forward buffer.
- Discards errored, oversize or overflowing frames by rewinding the write pointer.
- Forwards each good frame on the rxd data stream and issues one status word per frame on the rxs stream, for the S2MM DMA.

Parameters:
C_DATA_WIDTH, 64, data width in bits for MAC and rxd streams; 32, 64 or 128.
C_DEPTH_LOG2, 9, log2 of data buffer depth in beats.
C_STS_DEPTH_LOG2, 4, log2 of status FIFO depth in entries.
C_MAX_BYTES, 1522, largest accepted frame length in bytes.
C_DROP_ERR, 1, 1: drop frames with tuser set; 0: forward them with the error flag set in status.

Ports:
s2mm_clk  in  1  single clock for all logic
s2mm_resetn  in  1  asynchronous, active-low reset
rx_axis_mac_tdata  in  C_DATA_WIDTH  MAC receive data
rx_axis_mac_tkeep  in  C_DATA_WIDTH/8  byte enables, contiguous from bit 0
rx_axis_mac_tlast  in  1  last beat of frame
rx_axis_mac_tuser  in  1  frame error, sampled on the tlast beat only
rx_axis_mac_tvalid  in  1  beat valid
rx_axis_mac_tready  out  1  always 1 after reset (MAC cannot be stalled)
rxd_tdata  out  C_DATA_WIDTH  frame data to DMA
rxd_tkeep  out  C_DATA_WIDTH/8  byte enables
rxd_tlast  out  1  last beat of frame
rxd_tvalid  out  1  data valid
rxd_tready  in  1  DMA accepts data
rxs_tdata  out  32  status word
rxs_tkeep  out  4  constant 4'hF
rxs_tlast  out  1  constant 1 (single-beat status)
rxs_tvalid  out  1  status valid
rxs_tready  in  1  DMA accepts status
drop_cnt  out  16  count of dropped frames, saturating
ifm_fsm_dbg  out  2  input FSM state encoding

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-low.
- Output reset values while s2mm_resetn=0:
  - rx_axis_mac_tready=0.
  - All tvalid outputs=0; rxd_tdata, rxd_tkeep, rxd_tlast, rxs_tdata=0.
  - drop_cnt=0; ifm_fsm_dbg=0 (IDLE).
  - All pointers=0; buffer and status FIFO empty.
  - A partial frame held at reset is lost.
  - After release, the first valid beat is treated as a frame start.
- Buffer:
  - Dual-port RAM of 2^C_DEPTH_LOG2 entries {tlast, tkeep, tdata}.
  - Pointers: wr_spec (speculative), wr_commit, rd_ptr; all wrap modulo the depth.
  - Buffer is full when wr_spec+1 == rd_ptr, so usable capacity is depth-1 beats.
- Input FSM: IDLE(0), RECV(1), DROP(2).
  - IDLE: a valid beat starts a frame, is written and the byte count is loaded. Next state is RECV, or end-of-frame handling if tlast is set.
  - RECV: each valid beat is written; byte count += popcount(tkeep).
  - DROP: beats are discarded until tlast, then IDLE. No RAM writes.
  - Overflow (beat arrives while full) or byte count > C_MAX_BYTES: wr_spec := wr_commit and go to DROP. If that beat is tlast, the drop completes immediately and the FSM goes to IDLE.
- End of frame (tlast accepted, not dropping):
  - Drop: if tuser=1 and C_DROP_ERR=1, or the status FIFO is full, then wr_spec := wr_commit and drop_cnt increments.
  - Commit otherwise: wr_commit := wr_spec (including the tlast beat) and push the status word.
  - Commit and status push take effect on the same edge, the one following the tlast beat.
- Status word:
  - [15:0] = byte count.
  - [16] = tuser (nonzero only when C_DROP_ERR=0).
  - [31:17] = 0.
- drop_cnt: increments by 1 per dropped frame, whatever the cause; saturates at 16'hFFFF.
- Output side:
  - A beat is readable when rd_ptr != wr_commit.
  - One-cycle RAM read plus a two-entry output skid register, giving 1 beat/cycle sustained under rxd_tready=1.
  - First beat of a committed frame is on rxd exactly 2 cycles after the commit edge when the output is idle.
  - rxd holds all outputs stable while tvalid=1 and tready=0.
- rxs: presents the head of the status FIFO; pops on tvalid&tready. rxs and rxd are independent, with no ordering interlock.
- Simultaneous events:
  - A commit and a read in the same cycle are both honoured.
  - A write into the slot freed by a read in the same cycle is not allowed: full is evaluated on the registered rd_ptr.

Test Plan:
- 64-byte good frame, C_DATA_WIDTH=64 (8 beats, last tkeep=8'hFF) -> 8 rxd beats matching input, tlast on beat 8; rxs_tdata=32'h0000_0040; drop_cnt=0.
- 61-byte frame with tuser=1, C_DROP_ERR=1 -> no rxd or rxs output; drop_cnt=1; next good 60-byte frame -> rxs_tdata=32'h0000_003C, last tkeep=8'h0F.
- Same errored frame with C_DROP_ERR=0 -> 8 rxd beats; rxs_tdata=32'h0001_003D.
- C_DEPTH_LOG2=4, rxd_tready=0, 20-beat frame -> frame dropped, drop_cnt=1, ifm_fsm_dbg=2 until tlast; buffer stays empty; a subsequent 8-beat frame passes intact.
- 1600-byte frame -> dropped when the count crosses 1522; drop_cnt increments; next frame good.
- Assert s2mm_resetn=0 mid-frame with rxd stalled -> all outputs at reset values; after release a full 64-byte frame passes with correct status.

Source files
------------

// File: rtl/axi_eth_rx_fm.sv
// Store-and-forward receive frame manager: buffers MAC frames, drops bad frames by rewinding, emits data plus one status word per frame.
// MAC side never stalls; rxd/rxs obey valid-ready, first beat appears 2 cycles after the commit edge.

module axi_eth_rx_fm_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [W-1:0]        mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;

    assign head_vld = (wptr != rptr);
    assign full     = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                      (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    // Head reads as zero while empty so the status output idles at 0.
    assign head_dat = head_vld ? mem[rptr[DEPTH_LOG2-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[DEPTH_LOG2-1:0]] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + PTR_ONE;
            if (pop && head_vld) rptr <= rptr + PTR_ONE;
        end
    end
endmodule

module axi_eth_rx_fm #(
    parameter int C_DATA_WIDTH     = 64,
    parameter int C_DEPTH_LOG2     = 9,
    parameter int C_STS_DEPTH_LOG2 = 4,
    parameter int C_MAX_BYTES      = 1522,
    parameter int C_DROP_ERR       = 1
) (
    input  logic                      s2mm_clk,
    input  logic                      s2mm_resetn,
    input  logic [C_DATA_WIDTH-1:0]   rx_axis_mac_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] rx_axis_mac_tkeep,
    input  logic                      rx_axis_mac_tlast,
    input  logic                      rx_axis_mac_tuser,
    input  logic                      rx_axis_mac_tvalid,
    output logic                      rx_axis_mac_tready,
    output logic [C_DATA_WIDTH-1:0]   rxd_tdata,
    output logic [C_DATA_WIDTH/8-1:0] rxd_tkeep,
    output logic                      rxd_tlast,
    output logic                      rxd_tvalid,
    input  logic                      rxd_tready,
    output logic [31:0]               rxs_tdata,
    output logic [3:0]                rxs_tkeep,
    output logic                      rxs_tlast,
    output logic                      rxs_tvalid,
    input  logic                      rxs_tready,
    output logic [15:0]               drop_cnt,
    output logic [1:0]                ifm_fsm_dbg
);
    localparam int DW = C_DATA_WIDTH;
    localparam int KW = C_DATA_WIDTH / 8;
    localparam int PW = C_DEPTH_LOG2;
    localparam int EW = 1 + KW + DW;
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [15:0]   MAX_B    = 16'(C_MAX_BYTES);
    localparam logic          DROP_ERR = (C_DROP_ERR != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } ifm_state_t;

    ifm_state_t    state, state_nxt;
    logic [PW-1:0] wr_spec, wr_spec_nxt;
    logic [PW-1:0] wr_commit, wr_commit_nxt;
    logic [PW-1:0] rd_ptr;
    logic [15:0]   byte_cnt, byte_cnt_nxt, beat_bytes;
    logic          beat, buf_full, ram_we, sts_push, sts_full, drop_inc;
    logic [31:0]   sts_dat;

    logic [EW-1:0] mem [2**PW];
    logic [EW-1:0] ram_q, out0, out1;
    logic [1:0]    occ;
    logic          pend, pop_out, rd_issue;

    function automatic logic [15:0] popcnt(input logic [KW-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) n = n + {15'd0, k[i]};
        return n;
    endfunction

    assign beat     = rx_axis_mac_tvalid & rx_axis_mac_tready;
    // Full uses the registered rd_ptr, so a slot freed this cycle is only reusable next cycle.
    assign buf_full = ((wr_spec + PTR_ONE) == rd_ptr);
    assign beat_bytes = ((state == IDLE) ? 16'd0 : byte_cnt) + popcnt(rx_axis_mac_tkeep);
    assign sts_dat  = {15'd0, rx_axis_mac_tuser & ~DROP_ERR, beat_bytes};

    always_comb begin
        state_nxt     = state;
        wr_spec_nxt   = wr_spec;
        wr_commit_nxt = wr_commit;
        byte_cnt_nxt  = byte_cnt;
        ram_we        = 1'b0;
        sts_push      = 1'b0;
        drop_inc      = 1'b0;
        case (state)
            IDLE, RECV: begin
                if (beat) begin
                    byte_cnt_nxt = beat_bytes;
                    if (buf_full || (beat_bytes > MAX_B)) begin
                        wr_spec_nxt = wr_commit;
                        drop_inc    = 1'b1;
                        state_nxt   = rx_axis_mac_tlast ? IDLE : DROP;
                    end else begin
                        ram_we      = 1'b1;
                        wr_spec_nxt = wr_spec + PTR_ONE;
                        if (rx_axis_mac_tlast) begin
                            state_nxt = IDLE;
                            if ((rx_axis_mac_tuser && DROP_ERR) || sts_full) begin
                                wr_spec_nxt = wr_commit;
                                drop_inc    = 1'b1;
                            end else begin
                                wr_commit_nxt = wr_spec + PTR_ONE;
                                sts_push      = 1'b1;
                            end
                        end else begin
                            state_nxt = RECV;
                        end
                    end
                end
            end
            DROP: begin
                if (beat && rx_axis_mac_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            state              <= IDLE;
            wr_spec            <= '0;
            wr_commit          <= '0;
            byte_cnt           <= '0;
            drop_cnt           <= '0;
            rx_axis_mac_tready <= 1'b0;
        end else begin
            state              <= state_nxt;
            wr_spec            <= wr_spec_nxt;
            wr_commit          <= wr_commit_nxt;
            byte_cnt           <= byte_cnt_nxt;
            rx_axis_mac_tready <= 1'b1;
            if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign ifm_fsm_dbg = state;

    axi_eth_rx_fm_fifo #(
        .W          (32),
        .DEPTH_LOG2 (C_STS_DEPTH_LOG2)
    ) u_sts_fifo (
        .clk      (s2mm_clk),
        .rst_n    (s2mm_resetn),
        .push     (sts_push),
        .push_dat (sts_dat),
        .full     (sts_full),
        .pop      (rxs_tready),
        .head_vld (rxs_tvalid),
        .head_dat (rxs_tdata)
    );

    assign rxs_tkeep = 4'hF;
    assign rxs_tlast = 1'b1;

    // Issue a read only if the skid pair can absorb it, counting the beat already in flight.
    assign pop_out  = rxd_tvalid & rxd_tready;
    assign rd_issue = (rd_ptr != wr_commit) &&
                      (({1'b0, occ} + {2'b00, pend} - {2'b00, pop_out}) <= 3'd1);

    always_ff @(posedge s2mm_clk) begin
        if (ram_we) mem[wr_spec] <= {rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata};
        if (rd_issue) ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            rd_ptr <= '0;
            pend   <= 1'b0;
            occ    <= 2'd0;
            out0   <= '0;
            out1   <= '0;
        end else begin
            pend <= rd_issue;
            if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
            // out0 is the presented head; it only changes on a pop or when empty.
            case ({pend, pop_out})
                2'b10: begin
                    if (occ == 2'd0) out0 <= ram_q;
                    else             out1 <= ram_q;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    out0 <= out1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        out0 <= ram_q;
                    end else begin
                        out0 <= out1;
                        out1 <= ram_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rxd_tvalid = (occ != 2'd0);
    assign rxd_tlast  = out0[EW-1];
    assign rxd_tkeep  = out0[DW +: KW];
    assign rxd_tdata  = out0[DW-1:0];
endmodule

// File: tb/tb_axi_eth_rx_fm.sv
// Randomised and directed bench for axi_eth_rx_fm: one instance drops errored frames, the other forwards them.
`timescale 1ns/1ps
module tb_axi_eth_rx_fm;
    localparam int MAXB = 1522;

    logic        clk;
    logic        rst_n;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast, tuser, tvalid;
    logic        rxd_tready, rxs_tready;

    logic        a_mac_tready, a_rxd_tlast, a_rxd_tvalid, a_rxs_tlast, a_rxs_tvalid;
    logic [63:0] a_rxd_tdata;
    logic [7:0]  a_rxd_tkeep;
    logic [31:0] a_rxs_tdata;
    logic [3:0]  a_rxs_tkeep;
    logic [15:0] a_drop_cnt;
    logic [1:0]  a_dbg;
    logic        b_mac_tready, b_rxd_tlast, b_rxd_tvalid, b_rxs_tlast, b_rxs_tvalid;
    logic [63:0] b_rxd_tdata;
    logic [7:0]  b_rxd_tkeep;
    logic [31:0] b_rxs_tdata;
    logic [3:0]  b_rxs_tkeep;
    logic [15:0] b_drop_cnt;
    logic [1:0]  b_dbg;

    int total = 0;
    int bad   = 0;
    bit stall = 0;
    int drops_a = 0;
    int drops_b = 0;
    logic [72:0] exp_da[$];
    logic [72:0] exp_db[$];
    logic [31:0] exp_sa[$];
    logic [31:0] exp_sb[$];

    axi_eth_rx_fm dut_a (
        .s2mm_clk(clk), .s2mm_resetn(rst_n),
        .rx_axis_mac_tdata(tdata), .rx_axis_mac_tkeep(tkeep), .rx_axis_mac_tlast(tlast),
        .rx_axis_mac_tuser(tuser), .rx_axis_mac_tvalid(tvalid), .rx_axis_mac_tready(a_mac_tready),
        .rxd_tdata(a_rxd_tdata), .rxd_tkeep(a_rxd_tkeep), .rxd_tlast(a_rxd_tlast),
        .rxd_tvalid(a_rxd_tvalid), .rxd_tready(rxd_tready),
        .rxs_tdata(a_rxs_tdata), .rxs_tkeep(a_rxs_tkeep), .rxs_tlast(a_rxs_tlast),
        .rxs_tvalid(a_rxs_tvalid), .rxs_tready(rxs_tready),
        .drop_cnt(a_drop_cnt), .ifm_fsm_dbg(a_dbg)
    );

    axi_eth_rx_fm #(.C_DROP_ERR(0)) dut_b (
        .s2mm_clk(clk), .s2mm_resetn(rst_n),
        .rx_axis_mac_tdata(tdata), .rx_axis_mac_tkeep(tkeep), .rx_axis_mac_tlast(tlast),
        .rx_axis_mac_tuser(tuser), .rx_axis_mac_tvalid(tvalid), .rx_axis_mac_tready(b_mac_tready),
        .rxd_tdata(b_rxd_tdata), .rxd_tkeep(b_rxd_tkeep), .rxd_tlast(b_rxd_tlast),
        .rxd_tvalid(b_rxd_tvalid), .rxd_tready(rxd_tready),
        .rxs_tdata(b_rxs_tdata), .rxs_tkeep(b_rxs_tkeep), .rxs_tlast(b_rxs_tlast),
        .rxs_tvalid(b_rxs_tvalid), .rxs_tready(rxs_tready),
        .drop_cnt(b_drop_cnt), .ifm_fsm_dbg(b_dbg)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rxd_tready = 0;
        rxs_tready = 0;
        forever begin
            @(posedge clk); #1;
            rxd_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            rxs_tready = ($urandom_range(0, 2) != 0);
        end
    end

    // Scoreboard: every accepted output beat/status word must be the next expected one.
    bit          hold_a;
    logic [72:0] prev_a;
    always @(negedge clk) begin
        logic [72:0] e;
        logic [31:0] s;
        if (!rst_n) begin
            hold_a = 0;
        end else begin
            if (hold_a) chk("a_rxd_hold", {a_rxd_tvalid, a_rxd_tlast, a_rxd_tkeep, a_rxd_tdata}, {1'b1, prev_a});
            hold_a = a_rxd_tvalid && !rxd_tready;
            prev_a = {a_rxd_tlast, a_rxd_tkeep, a_rxd_tdata};
            if (a_rxd_tvalid && rxd_tready) begin
                if (exp_da.size() > 0) e = exp_da.pop_front(); else e = {73{1'bx}};
                chk("a_rxd_beat", {a_rxd_tlast, a_rxd_tkeep, a_rxd_tdata}, e);
            end
            if (b_rxd_tvalid && rxd_tready) begin
                if (exp_db.size() > 0) e = exp_db.pop_front(); else e = {73{1'bx}};
                chk("b_rxd_beat", {b_rxd_tlast, b_rxd_tkeep, b_rxd_tdata}, e);
            end
            if (a_rxs_tvalid && rxs_tready) begin
                if (exp_sa.size() > 0) s = exp_sa.pop_front(); else s = 32'hxxxx_xxxx;
                chk("a_rxs_word", a_rxs_tdata, s);
            end
            if (b_rxs_tvalid && rxs_tready) begin
                if (exp_sb.size() > 0) s = exp_sb.pop_front(); else s = 32'hxxxx_xxxx;
                chk("b_rxs_word", b_rxs_tdata, s);
            end
        end
    end

    // Drives one frame of len bytes; stop_after>=0 abandons it mid-frame, ovf marks an expected overflow drop.
    task automatic send_frame(input int len, input bit err, input bit gaps, input int dbg_beat,
                              input int stop_after, input bit ovf);
        int          nb;
        int          rem;
        logic [7:0]  k;
        logic [63:0] d;
        logic        last;
        logic [72:0] beats[$];
        nb = (len + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            if (stop_after >= 0 && i >= stop_after) break;
            rem  = len - 8 * i;
            k    = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            last = (i == nb - 1);
            d    = {$urandom, $urandom};
            while (gaps && $urandom_range(0, 4) == 0) begin
                tvalid = 0;
                tdata  = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            tvalid = 1; tdata = d; tkeep = k; tlast = last;
            tuser  = last ? err : 1'($urandom);
            @(posedge clk); #1;
            tvalid = 0; tlast = 0; tuser = 0;
            beats.push_back({last, k, d});
            if (i == dbg_beat) begin
                chk("a_fsm_drop", a_dbg, 2);
                chk("b_fsm_drop", b_dbg, 2);
            end
        end
        if (stop_after < 0) begin
            if (len <= MAXB && !ovf && !err) begin
                foreach (beats[j]) exp_da.push_back(beats[j]);
                exp_sa.push_back({16'd0, 16'(len)});
            end else drops_a++;
            if (len <= MAXB && !ovf) begin
                foreach (beats[j]) exp_db.push_back(beats[j]);
                exp_sb.push_back({15'd0, err, 16'(len)});
            end else drops_b++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_da.size() + exp_db.size() + exp_sa.size() + exp_sb.size()) != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        assert (n < 5000) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d expected=<5000", n);
        end
        chk("a_rxd_idle", a_rxd_tvalid, 0);
        chk("b_rxd_idle", b_rxd_tvalid, 0);
        chk("a_rxs_idle", a_rxs_tvalid, 0);
        chk("b_rxs_idle", b_rxs_tvalid, 0);
        chk("a_drop_cnt", a_drop_cnt, drops_a);
        chk("b_drop_cnt", b_drop_cnt, drops_b);
    endtask

    task automatic chk_reset_state();
        chk("a_rst_tready", a_mac_tready, 0);
        chk("b_rst_tready", b_mac_tready, 0);
        chk("a_rst_rxd", {a_rxd_tvalid, a_rxd_tlast, a_rxd_tkeep, a_rxd_tdata}, 0);
        chk("b_rst_rxd", {b_rxd_tvalid, b_rxd_tlast, b_rxd_tkeep, b_rxd_tdata}, 0);
        chk("a_rst_rxs", {a_rxs_tvalid, a_rxs_tdata}, 0);
        chk("b_rst_rxs", {b_rxs_tvalid, b_rxs_tdata}, 0);
        chk("a_rxs_const", {a_rxs_tkeep, a_rxs_tlast}, 5'h1F);
        chk("a_rst_drop", a_drop_cnt, 0);
        chk("b_rst_drop", b_drop_cnt, 0);
        chk("a_rst_fsm", a_dbg, 0);
        chk("b_rst_fsm", b_dbg, 0);
    endtask

    initial begin
        rst_n = 0; tvalid = 0; tdata = 0; tkeep = 0; tlast = 0; tuser = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        rst_n = 1;
        @(posedge clk); #1;
        chk("a_tready_up", a_mac_tready, 1);
        chk("b_tready_up", b_mac_tready, 1);

        // Good 64-byte frame, then errored 61-byte and good 60-byte frames.
        send_frame(64, 0, 0, -1, -1, 0);
        drain();
        send_frame(61, 1, 0, -1, -1, 0);
        send_frame(60, 0, 0, -1, -1, 0);
        drain();

        // Buffer overflow with rxd stalled: two near-max frames fit, the third overflows.
        stall = 1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(1520, 0, 0, -1, -1, 0);
        send_frame(1520, 0, 0, -1, -1, 0);
        send_frame(1520, 0, 0, 140, -1, 1);
        stall = 0;
        send_frame(64, 0, 0, -1, -1, 0);
        drain();

        // Length boundaries: oversize, exactly max, one over max on the tlast beat.
        send_frame(1600, 0, 0, 195, -1, 0);
        send_frame(100, 0, 0, -1, -1, 0);
        send_frame(MAXB, 0, 0, -1, -1, 0);
        send_frame(MAXB + 1, 0, 0, -1, -1, 0);
        send_frame(9, 0, 0, -1, -1, 0);
        drain();

        // Random bursts with idle gaps and random back-pressure.
        for (int burst = 0; burst < 10; burst++) begin
            for (int f = 0; f < 6; f++)
                send_frame($urandom_range(1, 320), ($urandom_range(0, 3) == 0), 1, -1, -1, 0);
            drain();
        end

        // Reset mid-frame while the output is stalled with data pending.
        stall = 1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(64, 0, 0, -1, -1, 0);
        send_frame(200, 0, 0, -1, 10, 0);
        chk("a_stalled_vld", a_rxd_tvalid, 1);
        tvalid = 1; tdata = {$urandom, $urandom}; tkeep = 8'hFF;
        rst_n = 0;
        #2;
        chk_reset_state();
        tvalid = 0;
        exp_da.delete(); exp_db.delete(); exp_sa.delete(); exp_sb.delete();
        drops_a = 0; drops_b = 0;
        stall = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        send_frame(64, 0, 0, -1, -1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
